// File: rtl/i2c_target_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_target_if : local byte-side interface of the I2C target
// Rev 1.0
// ---------------------------------------------------------------------------
interface i2c_target_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       addr_hit;
  logic       rw;
  logic       busy;
  logic       stop_det;

  // Local logic that feeds and consumes bytes.
  modport master (
    output tx_data,
    input  rx_data, rx_valid, tx_req, addr_hit, rw, busy, stop_det
  );

  // The I2C target itself.
  modport slave (
    input  tx_data,
    output rx_data, rx_valid, tx_req, addr_hit, rw, busy, stop_det
  );
endinterface
`default_nettype wire

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_target : oversampled I2C target, fixed 7-bit address, byte read/write
// Rev 1.0
// ---------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCL,
  inout  wire         SDA,
  i2c_target_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_IGNORE    = 3'd7
  } state_t;

  // Synchronizers preset high so an idle bus produces no edges out of reset.
  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= SCL;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= SDA;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;

  always_comb begin
    scl_rise   = scl_s2_q & ~scl_prev_q;
    scl_fall   = ~scl_s2_q & scl_prev_q;
    sda_rise   = sda_s2_q & ~sda_prev_q;
    sda_fall   = ~sda_s2_q & sda_prev_q;
    start_cond = sda_fall & scl_s2_q;
    stop_cond  = sda_rise & scl_s2_q;
  end

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       addr_hit_q, addr_hit_d;
  logic       busy_q, busy_d;
  logic       stop_det_q, stop_det_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
      stop_det_q <= stop_det_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    addr_hit_d = 1'b0;
    stop_det_d = 1'b0;

    if (start_cond) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_cond) begin
      state_d    = ST_IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDR) begin
              sda_oe_d   = 1'b1;
              addr_hit_d = 1'b1;
              rw_d       = shift_q[0];
              state_d    = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise && rw_q) begin
            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            if (rw_q) begin
              // Bit count tracks bits already driven, so the MSB counts as one.
              shift_d   = bus.tx_data;
              sda_oe_d  = ~bus.tx_data[7];
              bit_cnt_d = 4'd1;
              state_d   = ST_READ;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            state_d    = ST_WRITE_ACK;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_WRITE;
          end
        end
        ST_READ: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_READ_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_READ_ACK: begin
          // A non-zero count here marks that the host ACK has been seen.
          if (scl_rise) begin
            if (!sda_s2_q) begin
              tx_req_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d   = bus.tx_data;
            sda_oe_d  = ~bus.tx_data[7];
            bit_cnt_d = 4'd1;
            state_d   = ST_READ;
          end
        end
        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign SDA          = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.addr_hit = addr_hit_q;
  assign bus.rw       = rw_q;
  assign bus.busy     = busy_q;
  assign bus.stop_det = stop_det_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2c_target : bus-level host model with scoreboards for the I2C target
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_i2c_target;
  localparam int Q = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic host_sda_low = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  wire sda;

  pullup (sda);
  assign sda = host_sda_low ? 1'b0 : 1'bz;

  i2c_target_if bus_if ();
  assign bus_if.tx_data = tx_byte;

  i2c_target #(.ADDR(7'h42)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SCL   (scl),
    .SDA   (sda),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_hit = 0, n_rxv = 0, n_txr = 0, n_stop = 0, n_bfall = 0;
  logic busy_prev = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_q[$];
  logic       exp_rw[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Local-side scoreboard: compares DUT outputs as they appear and serves tx bytes.
  always @(negedge clk) begin
    if (bus_if.addr_hit) begin
      n_hit++;
      if (exp_rw.size() == 0) check_val("addr_hit_unexpected", 1, 0);
      else check_val("addr_rw", {31'd0, bus_if.rw}, {31'd0, exp_rw.pop_front()});
    end
    if (bus_if.rx_valid) begin
      n_rxv++;
      if (exp_rx.size() == 0) check_val("rx_valid_unexpected", 1, 0);
      else check_val("rx_data", {24'd0, bus_if.rx_data}, {24'd0, exp_rx.pop_front()});
    end
    if (bus_if.tx_req) begin
      n_txr++;
      if (tx_q.size() == 0) check_val("tx_req_unexpected", 1, 0);
      else tx_byte = tx_q.pop_front();
    end
    if (bus_if.stop_det) n_stop++;
    if (busy_prev && !bus_if.busy) n_bfall++;
    busy_prev = bus_if.busy;
  end

  task automatic clr_counts();
    n_hit = 0; n_rxv = 0; n_txr = 0; n_stop = 0; n_bfall = 0;
  endtask

  task automatic start_c();
    host_sda_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic rstart_c();
    host_sda_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    host_sda_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    host_sda_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    host_sda_low = 1'b0; #Q;
  endtask

  task automatic put_bit(input logic b);
    host_sda_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    host_sda_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    b = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    check_val(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic recv_byte(input logic nack);
    logic [7:0] got;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      got[i] = b;
    end
    put_bit(nack);
    if (exp_rd.size() == 0) check_val("rd_unexpected", 1, 0);
    else check_val("rd_byte", {24'd0, got}, {24'd0, exp_rd.pop_front()});
  endtask

  function automatic logic [13:0] outs();
    return {bus_if.rx_data, bus_if.rx_valid, bus_if.tx_req, bus_if.addr_hit,
            bus_if.rw, bus_if.busy, bus_if.stop_det};
  endfunction

  initial begin
    logic b;
    #3;
    check_val("reset_outputs", {18'd0, outs()}, 0);
    check_val("reset_sda", {31'd0, sda}, 1);
    #50 rst_n = 1'b1;
    #Q;

    // Write to own address
    clr_counts();
    exp_rw.push_back(1'b0);
    exp_rx.push_back(8'hA5);
    start_c();
    check_val("busy_after_start", {31'd0, bus_if.busy}, 1);
    send_byte(8'h84, 1'b0, "wr_addr_ack");
    send_byte(8'hA5, 1'b0, "wr_data_ack");
    stop_c();
    check_val("wr_hits", n_hit, 1);
    check_val("wr_rx_valids", n_rxv, 1);
    check_val("wr_stop_det", n_stop, 1);
    check_val("wr_busy_end", {31'd0, bus_if.busy}, 0);
    check_val("wr_busy_falls", n_bfall, 1);

    // Address mismatch
    clr_counts();
    start_c();
    send_byte(8'h86, 1'b1, "mis_addr_nack");
    send_byte(8'h11, 1'b1, "mis_data_nack");
    stop_c();
    check_val("mis_hits", n_hit, 0);
    check_val("mis_rx_valids", n_rxv, 0);
    check_val("mis_busy_end", {31'd0, bus_if.busy}, 0);
    check_val("mis_rx_hold", {24'd0, bus_if.rx_data}, 32'hA5);
    check_val("mis_stop_det", n_stop, 1);

    // Two-byte read, ACK then NACK
    clr_counts();
    exp_rw.push_back(1'b1);
    tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
    exp_rd.push_back(8'h3C); exp_rd.push_back(8'hC3);
    start_c();
    send_byte(8'h85, 1'b0, "rd_addr_ack");
    recv_byte(1'b0);
    recv_byte(1'b1);
    check_val("rd_sda_released", {31'd0, sda}, 1);
    stop_c();
    check_val("rd_tx_reqs", n_txr, 2);
    check_val("rd_hits", n_hit, 1);
    check_val("rd_rw_hold", {31'd0, bus_if.rw}, 1);

    // Repeated START after a partial write byte
    clr_counts();
    exp_rw.push_back(1'b0); exp_rw.push_back(1'b1);
    tx_q.push_back(8'h96);
    exp_rd.push_back(8'h96);
    start_c();
    send_byte(8'h84, 1'b0, "rs_addr1_ack");
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    rstart_c();
    check_val("rs_busy_mid", {31'd0, bus_if.busy}, 1);
    send_byte(8'h85, 1'b0, "rs_addr2_ack");
    recv_byte(1'b1);
    check_val("rs_busy_falls", n_bfall, 0);
    stop_c();
    check_val("rs_rx_valids", n_rxv, 0);
    check_val("rs_hits", n_hit, 2);
    check_val("rs_rw", {31'd0, bus_if.rw}, 1);

    // Back-to-back writes
    clr_counts();
    exp_rw.push_back(1'b0);
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'hFF);
    start_c();
    send_byte(8'h84, 1'b0, "b2b_addr_ack");
    send_byte(8'h01, 1'b0, "b2b_d0_ack");
    send_byte(8'h02, 1'b0, "b2b_d1_ack");
    send_byte(8'hFF, 1'b0, "b2b_d2_ack");
    stop_c();
    check_val("b2b_rx_valids", n_rxv, 3);

    // Reset while the target drives a low read bit
    clr_counts();
    exp_rw.push_back(1'b1);
    tx_q.push_back(8'h00);
    start_c();
    send_byte(8'h85, 1'b0, "rst_addr_ack");
    get_bit(b);
    get_bit(b);
    host_sda_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    check_val("rst_bit3_low", {31'd0, sda}, 0);
    rst_n = 1'b0; #1;
    check_val("rst_sda_released", {31'd0, sda}, 1);
    check_val("rst_outputs", {18'd0, outs()}, 0);
    #(Q-1);
    scl = 1'b0; #Q;
    rst_n = 1'b1; #Q;
    stop_c();

    clr_counts();
    exp_rw.push_back(1'b0);
    exp_rx.push_back(8'h5A);
    start_c();
    send_byte(8'h84, 1'b0, "post_addr_ack");
    send_byte(8'h5A, 1'b0, "post_data_ack");
    stop_c();
    check_val("post_rx_valids", n_rxv, 1);
    check_val("post_hits", n_hit, 1);

    #Q;
    check_val("left_exp_rx", exp_rx.size(), 0);
    check_val("left_exp_rw", exp_rw.size(), 0);
    check_val("left_exp_rd", exp_rd.size(), 0);
    check_val("left_tx_q", tx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) controller: the responder at the other end of the bus from the team's I2C host.
- Oversamples open-drain SCL/SDA on the fast system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, and moves bytes between the bus and a simple local byte interface: write bytes out to local logic, read bytes supplied by local logic.
- No clock stretching; SCL is input-only.

Parameters:
ADDR, 7'h42, 7-bit bus address this target responds to.

Ports:
clk  input  1  system clock; must be at least 16x the SCL rate.
rst_n  input  1  asynchronous active-low reset.
SCL  input  1  bus clock (sampled only, never driven).
SDA  inout  1  bus data; open-drain: driven 0 or released (z), never driven 1.
tx_data  input  8  byte to return on a read; sampled on the SCL fall that starts each read byte.
rx_data  output  8  last byte written by the host.
rx_valid  output  1  one-cycle pulse when rx_data updates.
tx_req  output  1  one-cycle pulse requesting the next tx_data.
addr_hit  output  1  one-cycle pulse on address match.
rw  output  1  R/W bit of the current transfer (1 = read).
busy  output  1  high from START until STOP.
stop_det  output  1  one-cycle pulse on STOP.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; rx_data=0; SDA released; state IDLE.
  - Synchronizer flops preset to 1, so bus-idle is seen after reset with no false edges.
- Input conditioning:
  - SCL and SDA each pass through 2-flop synchronizers; previous synced values are kept for edge detection.
  - scl_rise/scl_fall/sda_rise/sda_fall are single-cycle flags.
- Bus conditions:
  - START = sda_fall while synced SCL high.
  - STOP = sda_rise while synced SCL high.
  - Both take priority over all states. START (including repeated START) → ADDR, with bit count and shift register cleared, SDA released, busy=1.
  - STOP → IDLE, SDA released, busy=0, stop_det pulse.
- States:
  - IDLE: SDA released; waits for START.
  - ADDR:
    - Shift in SDA on each scl_rise, MSB first, for 8 bits ({addr, R/W}).
    - On the scl_fall after bit 8:
      - Match: drive SDA low, pulse addr_hit, latch rw, → ADDR_ACK.
      - Mismatch: → IGNORE (SDA released until the next START or STOP).
  - ADDR_ACK:
    - If rw=1, pulse tx_req on scl_rise.
    - On scl_fall:
      - rw=0: release SDA, → WRITE.
      - rw=1: load tx_data into the shift register, drive its MSB, → READ.
  - WRITE:
    - Shift in on scl_rise, 8 bits.
    - On the scl_fall after bit 8: rx_data ← byte, rx_valid pulse, drive SDA low (ACK; every byte is ACKed), → WRITE_ACK.
  - WRITE_ACK: on scl_fall release SDA, → WRITE.
  - READ:
    - Each bit is driven after scl_fall; driving means 0 = pull low, 1 = release.
    - After the 8th bit's scl_fall, release SDA, → READ_ACK.
  - READ_ACK:
    - On scl_rise sample SDA:
      - 0 (host ACK): pulse tx_req.
      - 1 (host NACK): → IGNORE.
    - On scl_fall after ACK: load tx_data, drive MSB, → READ.
  - IGNORE: SDA released; only START or STOP leave it.
- Boundary conditions:
  - A partial byte aborted by START or STOP is discarded; no rx_valid.
  - SDA is released on the same clk edge that STOP or START is detected.
  - A START arriving while SDA is driven low by the target cannot be detected; this is legal, since the host never issues START during a target ACK or data-low bit.
  - SDA transitions by the host while SCL is high are treated as START/STOP, never as data.
  - Bit counter is 4 bits and saturates at 8; no wrap.
  - rw and rx_data hold their values until overwritten.
  - busy stays 1 across a repeated START.

Test Plan:
- Write to matching address: START, 0x84 (0x42, W), byte 0xA5, STOP → addr_hit pulse, ACK low on both 9th clocks, rx_data=0xA5 with one rx_valid pulse, stop_det pulse, busy 1→0.
- Address mismatch: START, 0x86, byte 0x11, STOP → SDA never driven, no addr_hit, no rx_valid, busy returns to 0.
- Two-byte read: START, 0x85, tx_data=0x3C then 0xC3, host ACK then NACK, STOP → SDA carries 0x3C then 0xC3, exactly 2 tx_req pulses, SDA released after NACK.
- Repeated START: write 0x84 plus 4 bits of data, repeated START, 0x85 read → partial byte discarded (no rx_valid), rw=1, second addr_hit, busy held 1 throughout.
- Reset mid-read: assert rst_n=0 while the target is driving bit 3 low → SDA released asynchronously, all outputs 0; the next full write transaction works normally.
- Back-to-back writes: 0x84, 0x01, 0x02, 0xFF → three rx_valid pulses with 0x01, 0x02, 0xFF; ACK low on every 9th clock.
